wimuse_replay: RTL and testbench



---
 rtl/wimuse_replay_if.sv | 25 ++
 rtl/wimuse_replay.sv | 196 +++++++++++++++++++
 tb/tb_wimuse_replay.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wimuse_replay_if.sv
// Bundle of the FIFO read port and the local sound-chip bus driven by wimuse_replay.
interface wimuse_replay_if;
   logic        enable;
   logic [2:0]  esp_ct;
   logic [2:0]  esp_ad;
   logic [7:0]  esp_dt;
   logic        esp_req;
   logic [2:0]  snd_cs_n;
   logic        snd_a0;
   logic        snd_wr_n;
   logic [7:0]  snd_d;
   logic [7:0]  test_dt;
   logic        busy;
   logic [15:0] replay_cnt;

   modport slave (
      input  enable, esp_ct, esp_ad, esp_dt,
      output esp_req, snd_cs_n, snd_a0, snd_wr_n, snd_d, test_dt, busy, replay_cnt
   );

   modport master (
      output enable, esp_ct, esp_ad, esp_dt,
      input  esp_req, snd_cs_n, snd_a0, snd_wr_n, snd_d, test_dt, busy, replay_cnt
   );
endinterface

// File: rtl/wimuse_replay.sv
// Polls the WiMuse capture FIFO and replays each fresh register write onto the
// local OPLL / PSG / MSX-AUDIO bus; test-code entries only update test_dt.
module wimuse_replay #(
   parameter int SETUP   = 2,
   parameter int STROBE  = 4,
   parameter int HOLD    = 2,
   parameter int WAIT_AW = 4,
   parameter int WAIT_DW = 24,
   parameter int REQ_LOW = 4,
   parameter int SETTLE  = 6
) (
   input logic           clk,
   input logic           rst,
   wimuse_replay_if.slave bus
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_SAMPLE = 4'd1;
   localparam logic [3:0] ST_CHECK  = 4'd2;
   localparam logic [3:0] ST_SETUP  = 4'd3;
   localparam logic [3:0] ST_STROBE = 4'd4;
   localparam logic [3:0] ST_HOLD   = 4'd5;
   localparam logic [3:0] ST_WAIT   = 4'd6;
   localparam logic [3:0] ST_REQ_LO = 4'd7;
   localparam logic [3:0] ST_REQ_HI = 4'd8;

   // Word layout: [13:11] counter, [10:8] decoded address, [7:0] data
   logic [13:0] sync1, sync2, sync3;
   logic [13:0] smp;
   logic [3:0]  state;
   logic [7:0]  timer;
   logic [2:0]  last_ct;
   logic        req_q;
   logic [2:0]  cs_n_q;
   logic        a0_q;
   logic        wr_n_q;
   logic [7:0]  d_q;
   logic [7:0]  test_dt_q;
   logic        busy_q;
   logic [15:0] cnt_q;
   logic        stable;
   logic [7:0]  wait_last;

   // Chip-select pattern for a decoded address type (01 OPLL, 10 PSG, 11 MSX-AUDIO)
   function automatic logic [2:0] cs_decode(input logic [1:0] sel);
      logic [2:0] r;
      case (sel)
         2'b01:   r = 3'b110;
         2'b10:   r = 3'b101;
         2'b11:   r = 3'b011;
         default: r = 3'b111;
      endcase
      return r;
   endfunction

   assign stable    = (sync2 == sync3);
   assign wait_last = a0_q ? 8'(WAIT_DW - 1) : 8'(WAIT_AW - 1);

   // Two-stage synchronizer plus one extra stage for the stability compare
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= {bus.esp_ct, bus.esp_ad, bus.esp_dt};
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Poll / compare / replay sequencer with all bus outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         last_ct   <= '0;
         smp       <= '0;
         req_q     <= 1'b1;
         cs_n_q    <= 3'b111;
         a0_q      <= 1'b0;
         wr_n_q    <= 1'b1;
         d_q       <= '0;
         test_dt_q <= '0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (bus.enable) state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (!stable) begin
                  timer <= '0;
               end else if (timer == 8'd2) begin
                  timer <= '0;
                  smp   <= sync2;
                  state <= ST_CHECK;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_CHECK: begin
               timer <= '0;
               if (smp[13:11] == last_ct) begin
                  req_q <= 1'b0;
                  state <= ST_REQ_LO;
               end else begin
                  last_ct <= smp[13:11];
                  cnt_q   <= cnt_q + 16'd1;
                  if (smp[10:9] == 2'b00) begin
                     test_dt_q <= smp[7:0];
                     req_q     <= 1'b0;
                     state     <= ST_REQ_LO;
                  end else begin
                     cs_n_q <= cs_decode(smp[10:9]);
                     a0_q   <= smp[8];
                     d_q    <= smp[7:0];
                     busy_q <= 1'b1;
                     state  <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               if (timer == 8'(SETUP - 1)) begin
                  timer  <= '0;
                  wr_n_q <= 1'b0;
                  state  <= ST_STROBE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_STROBE: begin
               if (timer == 8'(STROBE - 1)) begin
                  timer  <= '0;
                  wr_n_q <= 1'b1;
                  state  <= ST_HOLD;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_HOLD: begin
               if (timer == 8'(HOLD - 1)) begin
                  timer  <= '0;
                  cs_n_q <= 3'b111;
                  state  <= ST_WAIT;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_WAIT: begin
               if (timer == wait_last) begin
                  timer  <= '0;
                  busy_q <= 1'b0;
                  req_q  <= 1'b0;
                  state  <= ST_REQ_LO;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_REQ_LO: begin
               if (timer == 8'(REQ_LOW - 1)) begin
                  timer <= '0;
                  req_q <= 1'b1;
                  state <= ST_REQ_HI;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            ST_REQ_HI: begin
               if (timer == 8'(SETTLE - 1)) begin
                  timer <= '0;
                  state <= bus.enable ? ST_SAMPLE : ST_IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: begin
               timer <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.esp_req    = req_q;
   assign bus.snd_cs_n   = cs_n_q;
   assign bus.snd_a0     = a0_q;
   assign bus.snd_wr_n   = wr_n_q;
   assign bus.snd_d      = d_q;
   assign bus.test_dt    = test_dt_q;
   assign bus.busy       = busy_q;
   assign bus.replay_cnt = cnt_q;

endmodule

// File: tb/tb_wimuse_replay.sv
// Bench for wimuse_replay: a queue-based FIFO model feeds the DUT, expected bus
// writes go into a scoreboard queue, and a monitor checks every bus cycle.
module tb_wimuse_replay;

   localparam int SETUP   = 2;
   localparam int STROBE  = 4;
   localparam int HOLD    = 2;
   localparam int WAIT_AW = 4;
   localparam int WAIT_DW = 24;
   localparam int REQ_LOW = 4;
   localparam int POLL    = 14;

   typedef struct packed {
      logic [2:0] ct;
      logic [2:0] ad;
      logic [7:0] dt;
   } entry_t;

   typedef struct packed {
      logic [2:0] cs_n;
      logic       a0;
      logic [7:0] d;
   } bus_wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   wimuse_replay_if bus();

   wimuse_replay dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   entry_t     fifo_q[$];
   entry_t     shown;
   bus_wr_t    exp_q[$];
   logic [2:0] cs_tbl [4] = '{3'b111, 3'b110, 3'b101, 3'b011};
   logic [2:0] wr_ct = 3'd0;
   int         model_cnt = 0;
   logic [7:0] model_test_dt = 8'h00;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         req_falls = 0;
   int         last_period = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: an entry the DUT will accept adds one to the count and
   // either a bus write or a new test register value
   task automatic expectAccept(input entry_t e);
      bus_wr_t b;
      model_cnt++;
      if (e.ad[2:1] == 2'b00) begin
         model_test_dt = e.dt;
      end else begin
         b.cs_n = cs_tbl[e.ad[2:1]];
         b.a0   = e.ad[0];
         b.d    = e.dt;
         exp_q.push_back(b);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] ad, input logic [7:0] dt);
      entry_t e;
      wr_ct  = wr_ct + 3'd1;
      e.ct   = wr_ct;
      e.ad   = ad;
      e.dt   = dt;
      fifo_q.push_back(e);
      expectAccept(e);
   endtask

   task automatic drive_shown();
      bus.esp_ct = shown.ct;
      bus.esp_ad = shown.ad;
      bus.esp_dt = shown.dt;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (fifo_q.size() > 0 && n < 4000) begin
         @(posedge clk);
         n++;
      end
      if (fifo_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_drain: %0d entries left, required 0", tag, fifo_q.size());
      end
      repeat (80) @(posedge clk);
      #1;
      checkOutput({tag, "_pending"}, exp_q.size(), 0);
      checkOutput({tag, "_replay_cnt"}, bus.replay_cnt, model_cnt[15:0]);
      checkOutput({tag, "_test_dt"}, bus.test_dt, model_test_dt);
   endtask

   // FIFO model: advances on a falling esp_req when something is queued
   initial begin : fifo_model
      logic prev_req;
      prev_req = 1'b1;
      forever begin
         @(negedge clk);
         if (prev_req && !bus.esp_req && fifo_q.size() > 0) begin
            shown = fifo_q.pop_front();
            drive_shown();
         end
         prev_req = bus.esp_req;
      end
   end

   // Monitor: pops the scoreboard on each WR fall and checks bus-cycle timing
   logic    m_prev_wr, m_prev_req, m_wait_pend, m_rise_a0;
   logic [2:0] m_prev_cs;
   int      m_cs_fall, m_wr_fall, m_wr_rise, m_cs_rise, m_req_fall;
   bus_wr_t m_e;

   initial begin : monitor
      m_prev_wr = 1'b1; m_prev_req = 1'b1; m_prev_cs = 3'b111; m_wait_pend = 1'b0;
      m_rise_a0 = 1'b0; m_cs_fall = 0; m_wr_fall = 0; m_wr_rise = 0; m_cs_rise = 0; m_req_fall = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            m_prev_wr = 1'b1; m_prev_req = 1'b1; m_prev_cs = 3'b111; m_wait_pend = 1'b0;
         end else begin
            if (m_prev_cs == 3'b111 && bus.snd_cs_n != 3'b111) begin
               m_cs_fall = cyc;
               checkOutput("cs_onehot", $countones(~bus.snd_cs_n), 1);
               checkOutput("busy_with_cs", bus.busy, 1'b1);
            end
            if (m_prev_wr && !bus.snd_wr_n) begin
               m_wr_fall = cyc;
               checkOutput("setup_len", cyc - m_cs_fall, SETUP);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_wr: cs_n=%b a0=%b d=%0h with no write required",
                           bus.snd_cs_n, bus.snd_a0, bus.snd_d);
               end else begin
                  m_e = exp_q.pop_front();
                  checkOutput("wr_cs_n", bus.snd_cs_n, m_e.cs_n);
                  checkOutput("wr_a0", bus.snd_a0, m_e.a0);
                  checkOutput("wr_d", bus.snd_d, m_e.d);
               end
            end
            if (!m_prev_wr && bus.snd_wr_n) begin
               m_wr_rise = cyc;
               checkOutput("strobe_len", cyc - m_wr_fall, STROBE);
            end
            if (m_prev_cs != 3'b111 && bus.snd_cs_n == 3'b111) begin
               m_cs_rise   = cyc;
               m_rise_a0   = bus.snd_a0;
               m_wait_pend = 1'b1;
               checkOutput("hold_len", cyc - m_wr_rise, HOLD);
            end
            if (m_prev_req && !bus.esp_req) begin
               checkOutput("busy_at_req", bus.busy, 1'b0);
               if (m_wait_pend)
                  checkOutput("wait_len", cyc - m_cs_rise, m_rise_a0 ? WAIT_DW : WAIT_AW);
               m_wait_pend = 1'b0;
               last_period = cyc - m_req_fall;
               m_req_fall  = cyc;
               req_falls++;
            end
            if (!m_prev_req && bus.esp_req)
               checkOutput("req_low_len", cyc - m_req_fall, REQ_LOW);
            m_prev_wr  = bus.snd_wr_n;
            m_prev_req = bus.esp_req;
            m_prev_cs  = bus.snd_cs_n;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int n0, n;
      int burst;
      shown      = '0;
      bus.enable = 1'b0;
      drive_shown();

      // Reset values with polling disabled
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_esp_req", bus.esp_req, 1'b1);
      checkOutput("rst_cs_n", bus.snd_cs_n, 3'b111);
      checkOutput("rst_a0", bus.snd_a0, 1'b0);
      checkOutput("rst_wr_n", bus.snd_wr_n, 1'b1);
      checkOutput("rst_d", bus.snd_d, 8'h00);
      checkOutput("rst_test_dt", bus.test_dt, 8'h00);
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_replay_cnt", bus.replay_cnt, 16'h0);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("idle_no_req", req_falls, 0);

      // Empty FIFO: periodic esp_req pulses only
      bus.enable = 1'b1;
      n0 = req_falls;
      n = 0;
      while (req_falls < n0 + 3 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("poll_count", req_falls >= n0 + 3, 1'b1);
      checkOutput("poll_period", last_period, POLL);
      checkOutput("empty_replay_cnt", bus.replay_cnt, 16'h0);

      // Single OPLL address write
      applyStimulus(3'b010, 8'h20);
      drain("opll");

      // Burst to PSG and MSX-AUDIO queued before polling reaches them
      applyStimulus(3'b100, 8'h07);
      applyStimulus(3'b101, 8'h38);
      applyStimulus(3'b110, 8'h08);
      applyStimulus(3'b111, 8'h00);
      drain("burst");

      // Test-code entry
      applyStimulus(3'b001, 8'h5A);
      drain("testcode");

      // Reset in the middle of a strobe
      applyStimulus(3'b101, 8'hC3);
      n = 0;
      while (bus.snd_wr_n !== 1'b0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("strobe_seen", bus.snd_wr_n, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_wr_n", bus.snd_wr_n, 1'b1);
      checkOutput("mid_rst_cs_n", bus.snd_cs_n, 3'b111);
      checkOutput("mid_rst_esp_req", bus.esp_req, 1'b1);
      checkOutput("mid_rst_busy", bus.busy, 1'b0);
      checkOutput("mid_rst_replay_cnt", bus.replay_cnt, 16'h0);
      rst = 1'b0;
      model_cnt = 0;
      model_test_dt = 8'h00;
      if (shown.ct != 3'd0) expectAccept(shown);
      drain("after_rst");

      // Nine writes wrapping the 3-bit counter, polled between writes
      for (int i = 0; i < 9; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
         drain("wrap");
      end

      // Random bursts
      for (int i = 0; i < 20; i++) begin
         burst = $urandom_range(1, 4);
         for (int j = 0; j < burst; j++)
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
         n = 0;
         while (fifo_q.size() > 0 && n < 4000) begin
            @(posedge clk);
            n++;
         end
         repeat ($urandom_range(0, 40)) @(posedge clk);
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
